mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares one single-port memory between the core's instruction-fetch port and data-access port. Each requester uses a valid/ready request handshake and receives a one-cycle response pulse. Exactly one transaction is outstanding at a time. The block sits between the fetch/load-store logic and a unified instruction/data memory, and serialises the memory's fixed read latency.

## Interface
Parameters:
- AW, 32: address width.
- DW, 32: data width.
- MEM_LAT, 2: memory read latency in cycles, legal range 1..7. mem_rdata is valid MEM_LAT cycles after the mem_en cycle.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst_n  input  1  synchronous, active-high reset. Asserted = 1; the name is kept for codebase consistency.
- if_req_valid  input  1  fetch read request.
- if_req_ready  output  1  fetch request accepted this cycle.
- if_addr  input  AW  fetch address.
- if_rsp_valid  output  1  one-cycle fetch response pulse.
- if_rdata  output  DW  fetch read data; valid only with if_rsp_valid.
- d_req_valid  input  1  data request.
- d_req_ready  output  1  data request accepted this cycle.
- d_we  input  1  1 = write, 0 = read.
- d_addr  input  AW  data address.
- d_wdata  input  DW  write data.
- d_rsp_valid  output  1  one-cycle data response pulse. Sent for both reads and writes.
- d_rdata  output  DW  read data; 0 for writes.
- mem_en  output  1  memory access strobe, registered.
- mem_we  output  1  memory write enable, registered.
- mem_addr  output  AW  memory address, registered.
- mem_wdata  output  DW  memory write data, registered.
- mem_rdata  input  DW  memory read data.

## Operation
The FSM has four states: IDLE, ISSUE, WAIT and RESP.

- **IDLE:** This is the only state in which a ready may be high. Ready is combinational from the valids and the arbitration state, and at most one ready is high.
  - On a handshake (valid & ready), the block latches the requester id, we, address and wdata, then moves to ISSUE.
  - A fetch request always sets we = 0.
  - With no valid, the block stays in IDLE.
- **ISSUE:** Lasts one cycle. mem_en = 1, and mem_we/addr/wdata carry the latched request. The WAIT counter loads MEM_LAT−1, and the FSM moves to WAIT.
- **WAIT:** Lasts MEM_LAT cycles, with mem_en = 0.
  - In the last WAIT cycle (counter = 0), mem_rdata is registered into the response data register for reads; for writes the register is cleared to 0.
  - The FSM then moves to RESP.
- **RESP:** Lasts one cycle. The granted requester's rsp_valid = 1 and its rdata carries the registered data. The other requester's rsp_valid = 0. The FSM then returns to IDLE.
- **Response data:** if_rdata and d_rdata hold their value between pulses; consumers must qualify them with rsp_valid.
- **Arbitration:** Default is fixed priority, data over fetch. The alternative policy is described under Configuration.
- **No back-pressure:** Requesters must accept the response pulse in its cycle.
- **Request hold:** A requester may drop valid while not granted; this is not an error.
- **Counter width:** 3 bits. MEM_LAT outside 1..7 is a configuration error; the implementation flags it with an elaboration-time check.

## Timing
- **Handshake to memory:** A handshake at cycle T gives ISSUE (mem_en) at T+1. Data is sampled at the end of cycle T+1+MEM_LAT. The response pulse is at T+2+MEM_LAT, and IDLE is reached at T+3+MEM_LAT.
- **Accept-to-response latency:** MEM_LAT+2 cycles.
- **Back-to-back throughput:** One transaction per MEM_LAT+3 cycles. The earliest next handshake is at T+3+MEM_LAT.
- **Reset values** (rst_n = 1 at a rising edge):
  - State = IDLE.
  - mem_en = mem_we = 0, mem_addr = mem_wdata = 0.
  - if_rsp_valid = d_rsp_valid = 0, if_rdata = d_rdata = 0.
  - Last-grant register = fetch.
- **Ready during reset:** Both readies are forced to 0 while rst_n = 1.
- **Reset mid-transaction:** The in-flight transaction is dropped. No response pulse is produced and mem_en goes to 0 on the next cycle. A write already strobed in ISSUE is not undone.
- **Simultaneous valids in IDLE:** Exactly one grant. The loser sees ready = 0 and must keep holding its request.

## Configuration
- **MEM_ARB_RR_EN defined:** Round-robin arbitration.
  - When both valids are high, the requester not granted last wins.
  - The last-grant register updates on every handshake.
  - A lone valid is always granted.
- **MEM_ARB_RR_EN undefined:** Fixed priority, data over fetch. The last-grant register is not implemented, and fetch can starve under continuous data traffic.

## Test plan
- **Fetch read:** MEM_LAT = 2, memory word 0x10 = 0xDEADBEEF. A fetch request for addr 0x10 handshakes at T → mem_en = 1, mem_addr = 0x10 at T+1; if_rsp_valid = 1 and if_rdata = 0xDEADBEEF at T+4; d_rsp_valid stays 0.
- **Data write then read:** A data write of 0x12345678 to 0x20 → mem_we = 1 in ISSUE; d_rsp_valid pulse with d_rdata = 0. A following data read of 0x20 → d_rdata = 0x12345678.
- **Contention, fixed priority (macro off):** Both valids held high for 3 transactions → all three grants go to data and if_req_ready never asserts. Dropping d_req_valid → fetch is granted next.
- **Contention, round-robin (macro on):** Both valids held high → grants alternate data, fetch, data, fetch. The first grant after reset goes to data, because last-grant resets to fetch.
- **Reset during WAIT:** With MEM_LAT = 4, assert rst_n in the second WAIT cycle → no rsp_valid pulse appears, all outputs read 0 on the next cycle, and a new request is accepted cleanly after reset is released.
- **MEM_LAT = 1 sweep and MEM_LAT = 7 sweep:** Response arrives exactly MEM_LAT+2 cycles after the handshake, and the next handshake is possible at MEM_LAT+3.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals of mem_arbiter.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          if_req_valid;
    logic          if_req_ready;
    logic [AW-1:0] if_addr;
    logic          if_rsp_valid;
    logic [DW-1:0] if_rdata;

    logic          d_req_valid;
    logic          d_req_ready;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_rsp_valid;
    logic [DW-1:0] d_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport master (
        output if_req_valid, if_addr, d_req_valid, d_we, d_addr, d_wdata, mem_rdata,
        input  if_req_ready, if_rsp_valid, if_rdata, d_req_ready, d_rsp_valid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  if_req_valid, if_addr, d_req_valid, d_we, d_addr, d_wdata, mem_rdata,
        output if_req_ready, if_rsp_valid, if_rdata, d_req_ready, d_rsp_valid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Serialises fetch and data requests onto one fixed-latency single-port memory.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is data-over-fetch priority.
module mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

    generate
        if (MEM_LAT < 1 || MEM_LAT > 7) begin : g_lat_chk
            $error("mem_arbiter: MEM_LAT must be in 1..7");
        end
    endgenerate

    logic [1:0]    r_state;
    logic [2:0]    r_cnt;
    logic          r_gnt_d;
    logic          r_we;
    logic          r_mem_en;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic          r_if_rsp;
    logic          r_d_rsp;
    logic [DW-1:0] r_if_rdata;
    logic [DW-1:0] r_d_rdata;

    logic w_idle;
    logic w_pick_d;
    logic w_if_rdy;
    logic w_d_rdy;

    // rst_n is active high despite its name; ready is gated off while it is asserted
    assign w_idle = (r_state == S_IDLE) && !rst_n;

`ifdef MEM_ARB_RR_EN
    logic r_last_d;
    assign w_pick_d = bus.d_req_valid && (!bus.if_req_valid || !r_last_d);
`else
    assign w_pick_d = bus.d_req_valid;
`endif

    assign w_d_rdy  = w_idle && w_pick_d;
    assign w_if_rdy = w_idle && bus.if_req_valid && !w_pick_d;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= 3'd0;
            r_gnt_d     <= 1'b0;
            r_we        <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rsp    <= 1'b0;
            r_d_rsp     <= 1'b0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
`ifdef MEM_ARB_RR_EN
            r_last_d    <= 1'b0;
`endif
        end else begin
            r_mem_en <= 1'b0;
            r_if_rsp <= 1'b0;
            r_d_rsp  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_d_rdy || w_if_rdy) begin
                        r_gnt_d     <= w_d_rdy;
                        r_we        <= w_d_rdy && bus.d_we;
                        r_mem_en    <= 1'b1;
                        r_mem_we    <= w_d_rdy && bus.d_we;
                        r_mem_addr  <= w_d_rdy ? bus.d_addr : bus.if_addr;
                        r_mem_wdata <= w_d_rdy ? bus.d_wdata : '0;
`ifdef MEM_ARB_RR_EN
                        r_last_d    <= w_d_rdy;
`endif
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_mem_we <= 1'b0;
                    r_cnt    <= LAT_M1;
                    r_state  <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_cnt == 3'd0) begin
                        // Memory data is valid only in this cycle; writes return 0
                        if (r_gnt_d) begin
                            r_d_rdata <= r_we ? '0 : bus.mem_rdata;
                            r_d_rsp   <= 1'b1;
                        end else begin
                            r_if_rdata <= bus.mem_rdata;
                            r_if_rsp   <= 1'b1;
                        end
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.if_req_ready = w_if_rdy;
    assign bus.d_req_ready  = w_d_rdy;
    assign bus.if_rsp_valid = r_if_rsp;
    assign bus.d_rsp_valid  = r_d_rsp;
    assign bus.if_rdata     = r_if_rdata;
    assign bus.d_rdata      = r_d_rdata;
    assign bus.mem_en       = r_mem_en;
    assign bus.mem_we       = r_mem_we;
    assign bus.mem_addr     = r_mem_addr;
    assign bus.mem_wdata    = r_mem_wdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: four instances (MEM_LAT 2,1,4,7) with behavioural memories,
// directed and random transactions checked against a transaction-level model.
module tb_mem_arbiter;
    localparam int NK = 4;

    function automatic int lat_of(input int k);
        case (k)
            0:       return 2;
            1:       return 1;
            2:       return 4;
            default: return 7;
        endcase
    endfunction

    function automatic logic [31:0] init_word(input int i);
        if (i == 4) return 32'hDEADBEEF;
        return 32'h5A00_0000 | (32'(i) * 32'h0000_0101);
    endfunction

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        fv [NK];
    logic        dv [NK];
    logic        dwe[NK];
    logic [31:0] fa [NK];
    logic [31:0] da [NK];
    logic [31:0] wd [NK];

    logic        ir [NK];
    logic        dr [NK];
    logic        irs[NK];
    logic        drs[NK];
    logic        men[NK];
    logic        mwe[NK];
    logic [31:0] ird[NK];
    logic [31:0] drd[NK];
    logic [31:0] madr[NK];
    logic [31:0] mwd[NK];

    for (genvar g = 0; g < NK; g++) begin : g_dut
        localparam int L = lat_of(g);
        mem_arbiter_if #(.AW(32), .DW(32)) bus();

        assign bus.if_req_valid = fv[g];
        assign bus.if_addr      = fa[g];
        assign bus.d_req_valid  = dv[g];
        assign bus.d_we         = dwe[g];
        assign bus.d_addr       = da[g];
        assign bus.d_wdata      = wd[g];

        assign ir[g]   = bus.if_req_ready;
        assign dr[g]   = bus.d_req_ready;
        assign irs[g]  = bus.if_rsp_valid;
        assign drs[g]  = bus.d_rsp_valid;
        assign ird[g]  = bus.if_rdata;
        assign drd[g]  = bus.d_rdata;
        assign men[g]  = bus.mem_en;
        assign mwe[g]  = bus.mem_we;
        assign madr[g] = bus.mem_addr;
        assign mwd[g]  = bus.mem_wdata;

        mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(L)) u_dut (
            .clk   (clk),
            .rst_n (rst),
            .bus   (bus)
        );

        // Memory: read data appears only in the cycle exactly L after mem_en, garbage otherwise
        logic [31:0] mem [64];
        logic [31:0] pipe[1:7];
        initial for (int i = 0; i < 64; i++) mem[i] = init_word(i);
        always @(posedge clk) begin
            if (bus.mem_en && bus.mem_we) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
            pipe[1] <= (bus.mem_en && !bus.mem_we) ? mem[bus.mem_addr[7:2]]
                                                   : ($urandom() | 32'h8000_0001);
            for (int s = 2; s <= 7; s++) pipe[s] <= pipe[s-1];
        end
        assign bus.mem_rdata = pipe[L];
    end

    int          n_cmp = 0;
    int          n_err = 0;
    bit          last_d[NK];
    logic [31:0] shadow[NK][64];

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Winner of the request pair per the arbitration rules; 1 = data
    function automatic bit exp_gnt(input int k, input bit f, input bit d);
        if (f && d) begin
`ifdef MEM_ARB_RR_EN
            return !last_d[k];
`else
            return 1'b1;
`endif
        end
        return d;
    endfunction

    task automatic check_reset_outputs(input int k);
        chk1 ("rst_if_ready",  ir[k],   1'b0);
        chk1 ("rst_d_ready",   dr[k],   1'b0);
        chk1 ("rst_if_rsp",    irs[k],  1'b0);
        chk1 ("rst_d_rsp",     drs[k],  1'b0);
        chk1 ("rst_mem_en",    men[k],  1'b0);
        chk1 ("rst_mem_we",    mwe[k],  1'b0);
        chk32("rst_mem_addr",  madr[k], 32'h0);
        chk32("rst_mem_wdata", mwd[k],  32'h0);
        chk32("rst_if_rdata",  ird[k],  32'h0);
        chk32("rst_d_rdata",   drd[k],  32'h0);
    endtask

    // Called just after a rising edge with DUT k idle; returns just after the edge that ends RESP.
    task automatic txn(input int k, input bit fvv, input bit dvv, input bit we,
                       input logic [31:0] fadr, input logic [31:0] dadr,
                       input logic [31:0] wdat, input bit hold);
        int          L;
        bit          gd;
        bit          wr;
        logic [31:0] exp_addr;
        logic [31:0] exp_rd;
        L = lat_of(k);
        fv[k] = fvv; dv[k] = dvv; dwe[k] = we; fa[k] = fadr; da[k] = dadr; wd[k] = wdat;
        @(negedge clk);
        gd = exp_gnt(k, fvv, dvv);
        chk1("if_ready", ir[k], !gd);
        chk1("d_ready",  dr[k], gd);
        last_d[k] = gd;
        exp_addr  = gd ? dadr : fadr;
        wr        = gd && we;
        exp_rd    = wr ? 32'h0 : shadow[k][exp_addr[7:2]];
        if (wr) shadow[k][dadr[7:2]] = wdat;
        @(posedge clk); #1;
        if (!hold) begin
            if (gd) dv[k] = 1'b0;
            else    fv[k] = 1'b0;
        end
        for (int c = 1; c <= L + 2; c++) begin
            @(negedge clk);
            chk1("ready_busy", ir[k] | dr[k], 1'b0);
            chk1("mem_en", men[k], c == 1);
            if (c == 1) begin
                chk1 ("mem_we",   mwe[k],  wr);
                chk32("mem_addr", madr[k], exp_addr);
                if (wr) chk32("mem_wdata", mwd[k], wdat);
            end
            chk1("if_rsp", irs[k], (c == L + 2) && !gd);
            chk1("d_rsp",  drs[k], (c == L + 2) && gd);
            if (c == L + 2) begin
                if (gd) chk32("d_rdata",  drd[k], exp_rd);
                else    chk32("if_rdata", ird[k], exp_rd);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int k, input int n);
        fv[k] = 1'b0; dv[k] = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk1("idle_ready",  ir[k] | dr[k],   1'b0);
            chk1("idle_rsp",    irs[k] | drs[k], 1'b0);
            chk1("idle_mem_en", men[k],          1'b0);
        end
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] rnd_addr();
        return 32'($urandom_range(0, 63)) << 2;
    endfunction

    initial begin
        for (int k = 0; k < NK; k++) begin
            fv[k] = 1'b1; dv[k] = 1'b1; dwe[k] = 1'b0;
            fa[k] = 32'h0; da[k] = 32'h0; wd[k] = 32'h0;
            last_d[k] = 1'b0;
            for (int i = 0; i < 64; i++) shadow[k][i] = init_word(i);
        end

        // Reset with both valids high: readies must stay low, all outputs zero
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < NK; k++) check_reset_outputs(k);
        @(posedge clk); #1;
        for (int k = 0; k < NK; k++) begin fv[k] = 1'b0; dv[k] = 1'b0; end
        rst = 1'b0;

        // Contention on MEM_LAT=2, then a lone fetch
        for (int i = 0; i < 4; i++) txn(0, 1'b1, 1'b1, 1'b0, 32'h40, rnd_addr(), 32'h0, 1'b1);
        txn(0, 1'b1, 1'b0, 1'b0, 32'h44, 32'h0, 32'h0, 1'b0);

        // Fetch read of the preloaded word, data write then read-back
        txn(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0);
        txn(0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h20, 32'h12345678, 1'b0);
        txn(0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h20, 32'h0, 1'b0);
        idle(0, 2);

        // Reset in the second WAIT cycle of a write on MEM_LAT=4
        fv[2] = 1'b0; dv[2] = 1'b1; dwe[2] = 1'b1; da[2] = 32'h30; wd[2] = 32'hCAFEF00D;
        @(negedge clk);
        chk1("rw_d_ready", dr[2], 1'b1);
        shadow[2][12] = 32'hCAFEF00D;
        @(posedge clk); #1;
        @(negedge clk);
        chk1("rw_mem_en", men[2], 1'b1);
        chk1("rw_mem_we", mwe[2], 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_reset_outputs(2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk1("rw_no_rsp", irs[2] | drs[2], 1'b0);
            chk1("rw_no_rdy", ir[2] | dr[2],   1'b0);
        end
        @(posedge clk); #1;
        dv[2] = 1'b0; dwe[2] = 1'b0;
        rst = 1'b0;
        for (int k = 0; k < NK; k++) last_d[k] = 1'b0;
        txn(2, 1'b0, 1'b1, 1'b0, 32'h0, 32'h30, 32'h0, 1'b0);
        txn(2, 1'b1, 1'b1, 1'b0, 32'h10, 32'h14, 32'h0, 1'b1);
        txn(2, 1'b1, 1'b1, 1'b0, 32'h10, 32'h14, 32'h0, 1'b0);
        idle(2, 1);

        // Back-to-back sweeps at MEM_LAT=1 and 7
        for (int k = 1; k < NK; k += 2) begin
            for (int i = 0; i < 4; i++)
                txn(k, i[0], !i[0], i[1], rnd_addr(), rnd_addr(), $urandom(), 1'b1);
            idle(k, 1);
        end

        // Random traffic across all instances
        for (int i = 0; i < 200; i++) begin
            int k;
            bit f, d;
            k = $urandom_range(0, NK - 1);
            f = 1'($urandom_range(0, 1));
            d = 1'($urandom_range(0, 1));
            if (!f && !d) f = 1'b1;
            txn(k, f, d, 1'($urandom_range(0, 1)), rnd_addr(), rnd_addr(), $urandom(),
                1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) idle(k, $urandom_range(1, 3));
            else begin fv[k] = 1'b0; dv[k] = 1'b0; end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
